// File: rtl/interval_sequencer.sv
// Interval sequencer: loads a start value, counts up on prescaled ticks
// until it reaches a terminal value, then pulses done and either returns
// to idle (one-shot) or reloads (periodic). The configuration is captured
// when a sequence starts, so mid-run input changes have no effect.
module interval_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [7:0] load_val,
    input  logic [7:0] term_val,
    input  logic [3:0] prescale,
    output logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic [1:0] state,
    output logic [7:0] periods
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     cur_state;
    logic [3:0] prescaler;
    logic [7:0] sh_load;
    logic [7:0] sh_term;
    logic [3:0] sh_prescale;
    logic       sh_mode;

    // Sequencer FSM; busy and done are registered alongside every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= IDLE;
            count       <= 8'd0;
            periods     <= 8'd0;
            prescaler   <= 4'd0;
            sh_load     <= 8'd0;
            sh_term     <= 8'd0;
            sh_prescale <= 4'd0;
            sh_mode     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start && !stop) begin
                        sh_load     <= load_val;
                        sh_term     <= term_val;
                        sh_prescale <= prescale;
                        sh_mode     <= mode;
                        periods     <= 8'd0;
                        cur_state   <= LOAD;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        cur_state <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        count     <= sh_load;
                        prescaler <= 4'd0;
                        cur_state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        cur_state <= IDLE;
                        busy      <= 1'b0;
                    end else if (prescaler == sh_prescale) begin
                        prescaler <= 4'd0;
                        if (count == sh_term) begin
                            cur_state <= DONE;
                            done      <= 1'b1;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end else begin
                        prescaler <= prescaler + 4'd1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (stop) begin
                        cur_state <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        if (periods != 8'hFF) begin
                            periods <= periods + 8'd1;
                        end
                        if (sh_mode) begin
                            cur_state <= LOAD;
                        end else begin
                            cur_state <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_interval_sequencer.sv
// Self-checking bench for interval_sequencer: directed scenarios plus a
// randomized run, all compared against a timeline model that derives each
// cycle's expected outputs from its position within the current period.
module tb_interval_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] load_val;
    logic [7:0] term_val;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;
    logic [7:0] periods;

    int total;
    int bad;

    // Reference model: position (edges since entering LOAD) within a period
    bit m_active;
    int m_pos;
    int m_load;
    int m_term;
    int m_pre;
    bit m_mode;
    int m_count;
    int m_periods;

    interval_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load_val (load_val),
        .term_val (term_val),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .state    (state),
        .periods  (periods)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Number of RUN cycles in one period: ticks needed times cycles per tick
    function automatic int run_len();
        return (((m_term - m_load) & 255) + 1) * (m_pre + 1);
    endfunction

    function automatic int m_state();
        if (!m_active) return 0;
        if (m_pos == 0) return 1;
        if (m_pos <= run_len()) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_pos     = 0;
        m_count   = 0;
        m_periods = 0;
    endtask

    task automatic model_step(input bit s, input bit sp, input bit md,
                              input int lv, input int tv, input int ps);
        if (!m_active) begin
            if (s && !sp) begin
                m_load    = lv;
                m_term    = tv;
                m_pre     = ps;
                m_mode    = md;
                m_periods = 0;
                m_active  = 1'b1;
                m_pos     = 0;
            end
        end else if (sp) begin
            m_active = 1'b0;
        end else if (m_state() == 3) begin
            if (m_periods < 255) m_periods++;
            if (m_mode) m_pos = 0;
            else m_active = 1'b0;
        end else begin
            m_pos++;
            if (m_state() == 3) m_count = m_term;
            else m_count = (m_load + (m_pos - 1) / (m_pre + 1)) & 255;
        end
    endtask

    task automatic compareAll(input string phase);
        int es;
        es = m_state();
        checkOutput({phase, ".state"},   int'(state),   es);
        checkOutput({phase, ".count"},   int'(count),   m_count);
        checkOutput({phase, ".periods"}, int'(periods), m_periods);
        checkOutput({phase, ".done"},    int'(done),    int'(es == 3));
        checkOutput({phase, ".busy"},    int'(busy),    int'(es != 0));
    endtask

    // Drive one cycle of inputs, advance the model over the edge, compare at negedge
    task automatic applyStimulus(input string phase, input bit s, input bit sp, input bit md,
                                 input logic [7:0] lv, input logic [7:0] tv, input logic [3:0] ps);
        start    = s;
        stop     = sp;
        mode     = md;
        load_val = lv;
        term_val = tv;
        prescale = ps;
        @(posedge clk);
        model_step(s, sp, md, int'(lv), int'(tv), int'(ps));
        @(negedge clk);
        compareAll(phase);
    endtask

    initial begin
        int exp_state [6];
        int exp_count [6];
        bit rs;
        bit rsp;
        bit rmd;
        logic [7:0] rlv;
        logic [7:0] rtv;
        logic [3:0] rps;

        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        load_val = 8'd0;
        term_val = 8'd0;
        prescale = 4'd0;
        model_reset();

        #7;
        compareAll("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // One-shot 10 -> 13, config inputs wiggled after start
        applyStimulus("os", 1'b1, 1'b0, 1'b0, 8'd10, 8'd13, 4'd0);
        checkOutput("os.load_state", int'(state), 1);
        exp_state = '{2, 2, 2, 2, 3, 0};
        exp_count = '{10, 11, 12, 13, 13, 13};
        for (int i = 0; i < 6; i++) begin
            applyStimulus("os", 1'b0, 1'b0, 1'b1, 8'h55, 8'hAA, 4'd7);
            checkOutput("os.const_state", int'(state), exp_state[i]);
            checkOutput("os.const_count", int'(count), exp_count[i]);
        end
        checkOutput("os.const_periods", int'(periods), 1);

        // Wrap 254 -> 1
        applyStimulus("wrap", 1'b1, 1'b0, 1'b0, 8'd254, 8'd1, 4'd0);
        for (int i = 0; i < 7; i++) applyStimulus("wrap", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);

        // Prescale 2, load 0 term 1
        applyStimulus("pre", 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 4'd2);
        for (int i = 0; i < 9; i++) applyStimulus("pre", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);

        // Periodic 5 -> 6 with load_val changing mid-run
        applyStimulus("per", 1'b1, 1'b0, 1'b1, 8'd5, 8'd6, 4'd0);
        for (int i = 0; i < 12; i++)
            applyStimulus("per", 1'b0, 1'b0, 1'b0, 8'(i * 17), 8'd0, 4'd0);
        checkOutput("per.const_periods", int'(periods), 3);
        applyStimulus("per", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd0);

        // Abort at count 7, then start+stop together in idle
        applyStimulus("abort", 1'b1, 1'b0, 1'b0, 8'd3, 8'd20, 4'd0);
        for (int i = 0; i < 5; i++) applyStimulus("abort", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        checkOutput("abort.pre_count", int'(count), 7);
        applyStimulus("abort", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd0);
        checkOutput("abort.state", int'(state), 0);
        checkOutput("abort.count", int'(count), 7);
        applyStimulus("abort", 1'b1, 1'b1, 1'b0, 8'd0, 8'd9, 4'd0);
        checkOutput("abort.startstop_state", int'(state), 0);

        // Asynchronous reset in the middle of RUN
        applyStimulus("areset", 1'b1, 1'b0, 1'b0, 8'd0, 8'd200, 4'd1);
        for (int i = 0; i < 6; i++) applyStimulus("areset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        checkOutput("areset.state", int'(state), 0);
        checkOutput("areset.count", int'(count), 0);
        checkOutput("areset.busy",  int'(busy),  0);
        checkOutput("areset.done",  int'(done),  0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("areset", 1'b1, 1'b0, 1'b0, 8'd4, 8'd5, 4'd0);
        checkOutput("areset.first_start", int'(state), 1);

        // Randomized traffic, config kept near the load value so periods finish
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 3) == 0);
            rsp = ($urandom_range(0, 19) == 0);
            rmd = 1'($urandom_range(0, 1));
            rlv = 8'($urandom_range(0, 255));
            rtv = rlv + 8'($urandom_range(0, 5));
            rps = 4'($urandom_range(0, 3));
            applyStimulus("rand", rs, rsp, rmd, rlv, rtv, rps);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interval_sequencer.md
INTERVAL_SEQUENCER -- requirements
Module: interval_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  begin a sequence; sampled only in IDLE.
REQ-005 stop  input  1  abort to IDLE; sampled in LOAD/RUN/DONE.
REQ-006 mode  input  1  0 = one-shot, 1 = periodic auto-reload.
REQ-007 load_val  input  8  count start value.
REQ-008 term_val  input  8  terminal count value.
REQ-009 prescale  input  4  tick divider, one tick every prescale+1 RUN cycles.
REQ-010 count  output  8  current count register.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  high for exactly the cycle(s) spent in DONE.
REQ-013 state  output  2  IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-014 periods  output  8  completed-period counter.

Function
REQ-015 All outputs SHALL be registered or Moore-decoded from registers; no combinational input-to-output paths.
REQ-016 IDLE, start=1, stop=0: capture load_val, term_val, mode and prescale into shadow registers, clear periods to 0, and go to LOAD.
REQ-017 Config inputs SHALL be ignored outside the IDLE-to-LOAD edge; mid-run changes SHALL have no effect.
REQ-018 LOAD, one cycle: count <= shadow load_val, prescaler <= 0, next state RUN.
REQ-019 RUN: a tick occurs on an edge where prescaler == shadow prescale; that edge clears the prescaler; other edges increment it.
REQ-020 RUN tick with count == shadow term_val: go to DONE and hold count.
REQ-021 RUN tick with count != shadow term_val: count <= count+1, wrapping modulo 256 (255 to 0).
REQ-022 load_val == term_val SHALL end on the first tick with no increment.
REQ-023 DONE, one cycle: periods <= periods+1, saturating at 255; next state LOAD if shadow mode=1, else IDLE.
REQ-024 stop=1 in LOAD, RUN or DONE: go to IDLE on that edge and override tick, reload and periods update; count holds.
REQ-025 A stop arriving in DONE SHALL still leave done high for that DONE cycle.
REQ-026 start while not IDLE SHALL be ignored; in IDLE, start and stop together SHALL leave the block in IDLE.
REQ-027 In IDLE, count and periods SHALL hold their last values.

Reset
REQ-028 While reset_n=0, asynchronously: state=IDLE, count=0, periods=0, prescaler=0, all shadow registers=0, busy=0, done=0.
REQ-029 Reset asserted mid-sequence SHALL abort immediately with no done pulse.
REQ-030 After reset_n deasserts, the first start SHALL be honoured on the first clk edge.

Verification
REQ-031 One-shot: load=10, term=13, prescale=0, start at edge E0 -> count=10 after E1, then 11/12/13 after E2/E3/E4; DONE after E5 (done=1 one cycle); IDLE after E6 with count=13, periods=1.
REQ-032 Wrap: load=254, term=1, prescale=0 -> count sequence 254, 255, 0, 1; then DONE; one done pulse.
REQ-033 Prescale: load=0, term=1, prescale=2 -> count becomes 1 at the 3rd RUN edge; DONE at the 6th RUN edge.
REQ-034 Periodic: load=5, term=6, prescale=0, mode=1 -> state repeats LOAD, RUN, RUN, DONE; done every 4 cycles; periods increments 1, 2, 3...; changing load_val mid-run has no effect.
REQ-035 Abort: stop during RUN at count=7 -> IDLE next edge, count stays 7, no done; start with stop=1 in IDLE -> stays IDLE.
REQ-036 Reset: reset_n low mid-RUN, between clock edges -> state=0, count=0, busy=0 immediately; start honoured on the first edge after release.
